// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX_MEM_* in, MEM_WB_* out, data memory over a req/ack handshake.
// Optional WAIT timeout with mem_fault abort is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_alures,
    input  logic [31:0] EX_MEM_dout_rs2,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_regwrite,
    input  logic [4:0]  EX_MEM_loadcntrl,
    input  logic [2:0]  EX_MEM_storecntrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] WB_res
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unrecognised or empty type fields fall back to word accesses.
    function automatic logic [1:0] access_size(input logic is_load, input logic [4:0] lc,
                                               input logic [2:0] sc);
        logic [1:0] sz;
        if (is_load) begin
            if (lc[0])      sz = SZ_BYTE;
            else if (lc[1]) sz = SZ_HALF;
            else if (lc[2]) sz = SZ_WORD;
            else if (lc[3]) sz = SZ_BYTE;
            else if (lc[4]) sz = SZ_HALF;
            else            sz = SZ_WORD;
        end else begin
            if (sc[0])      sz = SZ_BYTE;
            else if (sc[1]) sz = SZ_HALF;
            else if (sc[2]) sz = SZ_WORD;
            else            sz = SZ_WORD;
        end
        return sz;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                                 input logic [4:0] lc);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        if (lc[0])      r = {{24{b[7]}}, b};
        else if (lc[1]) r = {{16{h[15]}}, h};
        else if (lc[2]) r = word;
        else if (lc[3]) r = {24'd0, b};
        else if (lc[4]) r = {16'd0, h};
        else            r = word;
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        access_s, is_load_s, misaligned_s, timeout_s;
    logic [1:0]  size_s, addr_lo_s;
    logic        req_nxt_s, we_nxt_s, fault_nxt_s, wb_rw_nxt_s;
    logic [31:0] addr_nxt_s, wdata_nxt_s, wb_res_nxt_s;
    logic [3:0]  be_nxt_s;
    logic [4:0]  wb_rd_nxt_s;

    // Access classification and alignment check from the incoming EX_MEM fields.
    always_comb begin
        access_s  = EX_MEM_memread | EX_MEM_memwrite;
        is_load_s = EX_MEM_memread;
        addr_lo_s = EX_MEM_alures[1:0];
        size_s    = access_size(is_load_s, EX_MEM_loadcntrl, EX_MEM_storecntrl);
        case (size_s)
            SZ_HALF: misaligned_s = addr_lo_s[0];
            SZ_WORD: misaligned_s = (addr_lo_s != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    assign timeout_s = (state_r == ST_WAIT) && !dmem_ack &&
                       (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // WAIT-cycle counter: zero outside WAIT, so it is clear on every entry.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            wait_cnt_r <= '0;
        end else if ((state_r == ST_WAIT) && !dmem_ack) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end
`else
    logic unused_timeout_s;
    assign timeout_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

    // Stall is raised in the issue cycle itself and forced low while in reset.
    assign mem_stall = Rst && ((state_r == ST_WAIT) ||
                       (!dbg && access_s && !misaligned_s));

    // Next-state and next register values for the handshake FSM.
    always_comb begin
        state_nxt_s  = state_r;
        req_nxt_s    = dmem_req;
        we_nxt_s     = dmem_we;
        addr_nxt_s   = dmem_addr;
        be_nxt_s     = dmem_be;
        wdata_nxt_s  = dmem_wdata;
        fault_nxt_s  = 1'b0;
        wb_rd_nxt_s  = MEM_WB_rd;
        wb_rw_nxt_s  = MEM_WB_regwrite;
        wb_res_nxt_s = WB_res;
        case (state_r)
            ST_IDLE: begin
                if (dbg) begin
                    state_nxt_s = ST_IDLE;
                end else if (!access_s) begin
                    wb_rd_nxt_s  = EX_MEM_rd;
                    wb_rw_nxt_s  = EX_MEM_regwrite;
                    wb_res_nxt_s = EX_MEM_alures;
                end else if (misaligned_s) begin
                    fault_nxt_s  = 1'b1;
                    wb_rd_nxt_s  = EX_MEM_rd;
                    wb_rw_nxt_s  = 1'b0;
                    wb_res_nxt_s = 32'd0;
                end else begin
                    req_nxt_s   = 1'b1;
                    we_nxt_s    = !is_load_s;
                    addr_nxt_s  = {EX_MEM_alures[31:2], 2'b00};
                    be_nxt_s    = is_load_s ? 4'b1111 : store_be(size_s, addr_lo_s);
                    wdata_nxt_s = is_load_s ? 32'd0 : store_wdata(size_s, EX_MEM_dout_rs2);
                    wb_rw_nxt_s = 1'b0;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    req_nxt_s   = 1'b0;
                    we_nxt_s    = 1'b0;
                    addr_nxt_s  = 32'd0;
                    be_nxt_s    = 4'd0;
                    wdata_nxt_s = 32'd0;
                    wb_rd_nxt_s = EX_MEM_rd;
                    if (is_load_s) begin
                        wb_rw_nxt_s  = EX_MEM_regwrite;
                        wb_res_nxt_s = load_extract(dmem_rdata, addr_lo_s, EX_MEM_loadcntrl);
                    end else begin
                        wb_rw_nxt_s  = 1'b0;
                    end
                    state_nxt_s = ST_IDLE;
                end else if (timeout_s) begin
                    req_nxt_s    = 1'b0;
                    we_nxt_s     = 1'b0;
                    addr_nxt_s   = 32'd0;
                    be_nxt_s     = 4'd0;
                    wdata_nxt_s  = 32'd0;
                    fault_nxt_s  = 1'b1;
                    wb_rw_nxt_s  = 1'b0;
                    wb_res_nxt_s = 32'd0;
                    state_nxt_s  = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                req_nxt_s   = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, memory request and write-back registers.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_r         <= ST_IDLE;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_be         <= 4'd0;
            dmem_wdata      <= 32'd0;
            mem_fault       <= 1'b0;
            MEM_WB_rd       <= 5'd0;
            MEM_WB_regwrite <= 1'b0;
            WB_res          <= 32'd0;
        end else begin
            state_r         <= state_nxt_s;
            dmem_req        <= req_nxt_s;
            dmem_we         <= we_nxt_s;
            dmem_addr       <= addr_nxt_s;
            dmem_be         <= be_nxt_s;
            dmem_wdata      <= wdata_nxt_s;
            mem_fault       <= fault_nxt_s;
            MEM_WB_rd       <= wb_rd_nxt_s;
            MEM_WB_regwrite <= wb_rw_nxt_s;
            WB_res          <= wb_res_nxt_s;
        end
    end

endmodule
